pipeline_fetch_unit: RTL and testbench
======================================

Name: pipeline_fetch_unit

Overview:
Instruction fetch stage, directly upstream of the decode stage. Owns the architectural fetch PC and issues requests to a synchronous-read instruction memory. Buffers returned instructions in a small queue so that decode stalls do not lose in-flight reads. Presents {IR, PC, valid} to decode, and handles branch redirects and HALT.

Parameters:
PC_W, 8, fetch PC / instruction address width
IR_W, 16, instruction width
QDEPTH, 2, fetch queue entries (legal values 2..4)
RESET_PC, 8'h00, first fetch address after reset
NOP_IR, 16'h0000, IR_out value whenever valid_out=0

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
imem_req  out  1  read request this cycle
imem_addr  out  PC_W  read address, meaningful when imem_req=1
imem_rdata  in  IR_W  read data; valid exactly one cycle after the request
update_in  in  1  decode accepts head entry this cycle (pop); from hazard control
redirect_in  in  1  branch/jump taken; flush and refetch
redirect_pc  in  PC_W  redirect target
IR_out  out  IR_W  head instruction to decode
PC_out  out  PC_W  address of IR_out
valid_out  out  1  IR_out/PC_out hold a real instruction
halted_out  out  1  fetch stopped on HALT

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, queue empty, in-flight cleared, state=RUN. Outputs: imem_req=0, valid_out=0, IR_out=NOP_IR, PC_out=0, halted_out=0. rst overrides every other input in the same cycle.
- States: RUN, HALT.
- Issue, RUN only: imem_req=1 when count + inflight - pop < QDEPTH, where pop = update_in & valid_out.
- On issue: imem_addr=fetch_pc, fetch_pc <= fetch_pc+1 (modulo 2^PC_W, so 8'hFF wraps to 8'h00), inflight <= 1. Each inflight tag stores its PC.
- Response: the cycle after an unsquashed request, {imem_rdata, pc} is pushed into the queue and is visible at the head on the next cycle. Request-to-valid_out latency is 2 cycles. Steady-state throughput is 1 instruction/cycle with update_in=1.
- Output: valid_out = (count != 0). IR_out/PC_out come from the head entry when valid, otherwise NOP_IR / last PC_out.
- When update_in=0: IR_out/PC_out/valid_out stay stable. The queue absorbs at most the one in-flight response, so it never overflows.
- Simultaneous push and pop is allowed at any count, including full.
- Pop when empty: ignored.
- Redirect (redirect_in=1): at the edge, queue flushed, any in-flight response squashed (its data is dropped next cycle), fetch_pc <= redirect_pc, state <= RUN.
  - From the next cycle: valid_out=0; first request to redirect_pc issues that cycle.
  - Redirect has priority over pop/push in the same cycle.
  - Redirect while HALT restarts fetch.
- HALT detect: a pushed entry with IR[15:13]==3'b111 enters the queue normally. At that edge, state <= HALT and any request issued in that same cycle is squashed.
  - In HALT: imem_req=0, halted_out=1.
  - Queued entries (including the HALT instruction) still drain via update_in.
- Back-to-back redirects: each redirect re-flushes; only the last target is fetched.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetch_cnt_out[15:0] (pushes accepted) and stall_cnt_out[15:0] (cycles with valid_out=1 & update_in=0). Both counters saturate at 16'hFFFF and clear on rst.
- Not defined: the ports and counters are absent; no other behaviour changes.

Decomposition:
- Shared package kl_fetch_pkg: OP_HALT=3'b111; NOP_IR; PC_W/IR_W defaults; packed struct fetch_entry_t {pc, ir}; state enum {RUN, HALT}.
- One sub-module: fetch_queue, a parameterised QDEPTH FIFO of fetch_entry_t with push/pop/flush and a count output. Pop-and-push when full is legal.

Test Plan:
- Reset, then update_in=1, imem returns IR=addr+16'h1000 -> imem_addr 00,01,02... every cycle; first valid_out 2 cycles after the first req; IR_out 1000,1001,...; PC_out matches.
- Hold update_in=0 for 5 cycles mid-stream -> IR_out/PC_out frozen, imem_req drops once count+inflight=2, no instruction lost or duplicated on release.
- Redirect to 8'h40 while the queue is full and a request is in flight -> next cycle valid_out=0, squashed data never appears; PC_out sequence resumes 40,41.
- IR=16'hE000 at addr 05 -> HALT delivered with PC_out=05, no request for 06 is used, halted_out=1, imem_req stays 0; redirect to 10 -> fetch resumes at 10, halted_out=0.
- Start fetch_pc at 8'hFE -> addresses FE,FF,00 with no glitch.
- Assert rst mid-stream with redirect_in also high -> RESET_PC fetched, redirect ignored.

Source files
------------

// File: rtl/kl_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package kl_fetch_pkg;

    localparam int unsigned FETCH_PC_W = 8;
    localparam int unsigned FETCH_IR_W = 16;
    localparam logic [2:0]  OP_HALT    = 3'b111;
    localparam logic [15:0] NOP_IR     = 16'h0000;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [FETCH_IR_W-1:0] ir;
    } fetch_entry_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, ir} entries; flush empties it, pop-and-push when full is legal.
module fetch_queue
    import kl_fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned QDEPTH  = 2,
    localparam int unsigned CW     = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count
);

    localparam int unsigned    PW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam logic [PW-1:0]  LAST = PW'(QDEPTH - 1);
    localparam logic [CW-1:0]  FULL = CW'(QDEPTH);

    entry_t        mem [QDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: PC sequencing, imem requests, fetch queue, redirect and HALT.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module pipeline_fetch_unit
    import kl_fetch_pkg::*;
#(
    parameter int unsigned      PC_W     = FETCH_PC_W,
    parameter int unsigned      IR_W     = FETCH_IR_W,
    parameter int unsigned      QDEPTH   = 2,
    parameter logic [PC_W-1:0]  RESET_PC = '0,
    parameter logic [IR_W-1:0]  NOP_IR   = IR_W'(kl_fetch_pkg::NOP_IR)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [IR_W-1:0] imem_rdata,
    input  logic            update_in,
    input  logic            redirect_in,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [IR_W-1:0] IR_out,
    output logic [PC_W-1:0] PC_out,
    output logic            valid_out,
    output logic            halted_out
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]     fetch_cnt_out,
    output logic [15:0]     stall_cnt_out
`endif
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [IR_W-1:0] ir;
    } entry_t;

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_t    state_q;
    logic [PC_W-1:0] fetch_pc_q, inflight_pc_q, last_pc_q;
    logic            inflight_q;
    logic [CW-1:0]   count;
    entry_t          head, push_entry;
    logic            pop, push, issue, halt_push;

    assign valid_out = (count != '0);
    assign pop       = update_in & valid_out;

    // count + inflight - pop < QDEPTH, rearranged so nothing goes negative
    assign issue = ~rst && (state_q == RUN) &&
                   ((CW+2)'(count) + (CW+2)'(inflight_q) < (CW+2)'(QDEPTH) + (CW+2)'(pop));

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;

    // A redirect in the response cycle drops the returning word
    assign push       = inflight_q & ~redirect_in;
    assign push_entry = '{pc: inflight_pc_q, ir: imem_rdata};
    assign halt_push  = push && (imem_rdata[IR_W-1 -: 3] == OP_HALT);

    fetch_queue #(
        .entry_t (entry_t),
        .QDEPTH  (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_in),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop & ~redirect_in),
        .head      (head),
        .count     (count)
    );

    assign IR_out     = valid_out ? head.ir : NOP_IR;
    assign PC_out     = valid_out ? head.pc : last_pc_q;
    assign halted_out = (state_q == HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            last_pc_q     <= '0;
        end else begin
            if (valid_out) begin
                last_pc_q <= head.pc;
            end
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
            end
            if (redirect_in) begin
                state_q    <= RUN;
                fetch_pc_q <= redirect_pc;
                inflight_q <= 1'b0;
            end else begin
                // the request issued alongside a HALT push is squashed
                inflight_q <= issue & ~halt_push;
                if (issue) begin
                    fetch_pc_q <= fetch_pc_q + 1'b1;
                end
                if (halt_push) begin
                    state_q <= HALT;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_out <= '0;
            stall_cnt_out <= '0;
        end else begin
            if (push && (fetch_cnt_out != '1)) begin
                fetch_cnt_out <= fetch_cnt_out + 1'b1;
            end
            if (valid_out && !update_in && (stall_cnt_out != '1)) begin
                stall_cnt_out <= stall_cnt_out + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Self-checking bench for pipeline_fetch_unit: cycle vector table plus scoreboard-driven phases.
module tb_pipeline_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, imem_req, update_in, redirect_in, valid_out, halted_out;
    logic [7:0]  imem_addr, redirect_pc, PC_out;
    logic [15:0] imem_rdata, IR_out;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, stall_cnt;
`endif

    logic        halt_en;
    logic [7:0]  halt_addr;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    pipeline_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .update_in   (update_in),
        .redirect_in (redirect_in),
        .redirect_pc (redirect_pc),
        .IR_out      (IR_out),
        .PC_out      (PC_out),
        .valid_out   (valid_out),
        .halted_out  (halted_out)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_out (fetch_cnt),
        .stall_cnt_out (stall_cnt)
`endif
    );

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        if (halt_en && (a == halt_addr)) return 16'hE000;
        return {8'h10, a};
    endfunction

    // synchronous-read instruction memory
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, upd, redir;
        logic [7:0]  rpc;
        logic        req;
        logic [7:0]  addr;
        logic        valid;
        logic [7:0]  pc;
        logic [15:0] ir;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic u, input logic d, input logic [7:0] rp,
                                input logic q, input logic [7:0] a, input logic v,
                                input logic [7:0] p, input logic [15:0] i);
        vec_t t;
        t.rst = r; t.upd = u; t.redir = d; t.rpc = rp;
        t.req = q; t.addr = a; t.valid = v; t.pc = p; t.ir = i;
        return t;
    endfunction

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ir;
    } exp_t;

    exp_t sb[$];

    task automatic start_redirect(input logic [7:0] target);
        @(negedge clk);
        rst = 1'b0;
        update_in = 1'b0;
        redirect_in = 1'b1;
        redirect_pc = target;
    endtask

    task automatic expect_range(input logic [7:0] first, input int n);
        logic [7:0] a;
        a = first;
        for (int k = 0; k < n; k++) begin
            sb.push_back('{pc: a, ir: mem_word(a)});
            a = a + 8'd1;
        end
    endtask

    task automatic deliver(input int budget, input bit rnd);
        exp_t e;
        int   n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            rst = 1'b0;
            redirect_in = 1'b0;
            update_in = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (valid_out && update_in) begin
                e = sb.pop_front();
                chk("deliver_pc", 32'(PC_out), 32'(e.pc));
                chk("deliver_ir", 32'(IR_out), 32'(e.ir));
            end
            n++;
        end
        if (sb.size() != 0) begin
            chk("deliver_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    vec_t vecs[17];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; update_in = 1'b0; redirect_in = 1'b0; redirect_pc = 8'h00;
        halt_en = 1'b0; halt_addr = 8'h00;

        //            rst upd red rpc    req addr   val pc     ir
        vecs[0]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 16'h0000);
        vecs[1]  = mk(0, 1, 0, 8'h00, 1, 8'h00, 0, 8'h00, 16'h0000);
        vecs[2]  = mk(0, 1, 0, 8'h00, 1, 8'h01, 0, 8'h00, 16'h0000);
        vecs[3]  = mk(0, 1, 0, 8'h00, 1, 8'h02, 1, 8'h00, 16'h1000);
        vecs[4]  = mk(0, 1, 0, 8'h00, 1, 8'h03, 1, 8'h01, 16'h1001);
        vecs[5]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h02, 16'h1002);
        vecs[6]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h02, 16'h1002);
        vecs[7]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h02, 16'h1002);
        vecs[8]  = mk(0, 1, 0, 8'h00, 1, 8'h04, 1, 8'h02, 16'h1002);
        vecs[9]  = mk(0, 1, 0, 8'h00, 1, 8'h05, 1, 8'h03, 16'h1003);
        vecs[10] = mk(0, 1, 0, 8'h00, 1, 8'h06, 1, 8'h04, 16'h1004);
        vecs[11] = mk(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h05, 16'h1005);
        vecs[12] = mk(0, 1, 1, 8'h40, 1, 8'h07, 1, 8'h05, 16'h1005);
        vecs[13] = mk(0, 1, 0, 8'h00, 1, 8'h40, 0, 8'h05, 16'h0000);
        vecs[14] = mk(0, 1, 0, 8'h00, 1, 8'h41, 0, 8'h05, 16'h0000);
        vecs[15] = mk(0, 1, 0, 8'h00, 1, 8'h42, 1, 8'h40, 16'h1040);
        vecs[16] = mk(0, 1, 0, 8'h00, 1, 8'h43, 1, 8'h41, 16'h1041);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            update_in = vecs[i].upd;
            redirect_in = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            #1;
            chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) chk($sformatf("v%0d_addr", i), 32'(imem_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].valid));
            chk($sformatf("v%0d_pc", i), 32'(PC_out), 32'(vecs[i].pc));
            chk($sformatf("v%0d_ir", i), 32'(IR_out), 32'(vecs[i].ir));
            chk($sformatf("v%0d_halted", i), 32'(halted_out), 32'd0);
        end

        // HALT at address 05: delivered last, nothing after it, fetch stops
        halt_en = 1'b1; halt_addr = 8'h05;
        start_redirect(8'h00);
        expect_range(8'h00, 6);
        deliver(100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            redirect_in = 1'b0;
            update_in = 1'b1;
            #1;
            chk("halt_valid", 32'(valid_out), 32'd0);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_flag", 32'(halted_out), 32'd1);
        end

        // redirect out of HALT restarts fetch at the target
        halt_en = 1'b0;
        start_redirect(8'h10);
        @(negedge clk);
        redirect_in = 1'b0;
        update_in = 1'b1;
        #1;
        chk("restart_halted", 32'(halted_out), 32'd0);
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", 32'(imem_addr), 32'h10);
        chk("restart_valid", 32'(valid_out), 32'd0);
        expect_range(8'h10, 5);
        deliver(60, 1'b1);

        // PC wraps FF -> 00
        start_redirect(8'hFE);
        expect_range(8'hFE, 4);
        deliver(40, 1'b0);

        // reset mid-stream beats a simultaneous redirect
        @(negedge clk);
        rst = 1'b1;
        redirect_in = 1'b1;
        redirect_pc = 8'h77;
        update_in = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        redirect_in = 1'b0;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_pc", 32'(PC_out), 32'd0);
        chk("rst_ir", 32'(IR_out), 32'd0);
        chk("rst_halted", 32'(halted_out), 32'd0);
        chk("rst_req_after", 32'(imem_req), 32'd1);
        chk("rst_addr", 32'(imem_addr), 32'h00);
        expect_range(8'h00, 4);
        deliver(60, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
